mpi_rx_arbiter: RTL and testbench

Credit-based inbound arbiter for the Metro-MPI receive path. It terminates `NUM_CH` independent valid/yummy channels, each arriving from a DPI receive endpoint. Each channel gets its own small buffer. The block merges all channels round-robin onto one registered 64-bit valid/ready output that feeds the local NoC injection port. Credits go back to each sender as one-cycle yummy pulses when its buffered flit is forwarded.

---
 rtl/metro_mpi_pkg.sv | 28 ++
 rtl/mpi_credit_fifo.sv | 87 ++++++++
 rtl/mpi_rx_arbiter.sv | 154 +++++++++++++++
 tb/tb_mpi_rx_arbiter.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/metro_mpi_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : metro_mpi_pkg
//  Purpose  : Shared types and constants for the Metro-MPI receive path.
//             - mpi_flit_t   : 64-bit flit payload plus source channel
//             - MPI_RX_MAX_CH / MPI_RX_MAX_DEPTH : legal parameter ceilings
//             - rr_index()   : round-robin candidate index helper
//  Revision : 1.0  initial release
// ============================================================================
package metro_mpi_pkg;

    localparam int MPI_RX_MAX_CH    = 8;
    localparam int MPI_RX_MAX_DEPTH = 4;
    localparam int MPI_RX_CHAN_W    = $clog2(MPI_RX_MAX_CH);

    typedef struct packed {
        logic [63:0]              data;
        logic [MPI_RX_CHAN_W-1:0] chan;
    } mpi_flit_t;

    // Channel examined at position 'offset' of a round-robin scan that
    // starts just after 'last'.
    function automatic int rr_index(input int last, input int offset, input int n);
        return (last + offset) % n;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mpi_credit_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : mpi_credit_fifo
//  Purpose  : Per-channel flit buffer sized to the sender's credit count.
//             A push is accepted when not full, or when full but popped in
//             the same cycle. A push that cannot be accepted is dropped and
//             flagged on o_overflow for that cycle.
//  Ports    : clk_i, rstn_i (async, active-low)
//             i_push/i_data   - incoming flit
//             i_pop           - remove head entry (caller guarantees !o_empty)
//             o_data          - head entry (combinational read)
//             o_empty/o_full  - occupancy status
//             o_overflow      - one-cycle pulse on a dropped push
//  Revision : 1.0  initial release
// ============================================================================
module mpi_credit_fifo
    import metro_mpi_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic        clk_i,
    input  logic        rstn_i,
    input  logic        i_push,
    input  logic [63:0] i_data,
    input  logic        i_pop,
    output logic [63:0] o_data,
    output logic        o_empty,
    output logic        o_full,
    output logic        o_overflow
);

    localparam int c_CNT_W = $clog2(DEPTH + 1);
    localparam int c_PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [c_PTR_W-1:0] c_PTR_LAST = c_PTR_W'(DEPTH - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_FULL = c_CNT_W'(DEPTH);

    generate
        if (DEPTH < 1 || DEPTH > MPI_RX_MAX_DEPTH) begin : g_depth_chk
            $error("mpi_credit_fifo: DEPTH out of range");
        end
    endgenerate

    logic [63:0]        r_mem [DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_CNT_W-1:0] r_count;
    logic               w_write;

    function automatic logic [c_PTR_W-1:0] ptr_inc(input logic [c_PTR_W-1:0] p);
        return (p == c_PTR_LAST) ? '0 : p + c_PTR_W'(1);
    endfunction

    assign o_empty    = (r_count == '0);
    assign o_full     = (r_count == c_CNT_FULL);
    assign w_write    = i_push & (~o_full | i_pop);
    assign o_overflow = i_push & o_full & ~i_pop;
    assign o_data     = r_mem[r_rd_ptr];

    // Storage carries no reset: an entry is only ever read after being written.
    always_ff @(posedge clk_i) begin
        if (w_write) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_write) begin
                r_wr_ptr <= ptr_inc(r_wr_ptr);
            end
            if (i_pop) begin
                r_rd_ptr <= ptr_inc(r_rd_ptr);
            end
            case ({w_write, i_pop})
                2'b10:   r_count <= r_count + c_CNT_W'(1);
                2'b01:   r_count <= r_count - c_CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/mpi_rx_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : mpi_rx_arbiter
//  Purpose  : Credit-based inbound arbiter. NUM_CH valid/yummy channels are
//             each buffered in an mpi_credit_fifo and merged round-robin
//             onto one registered valid/ready output slot. Every pop returns
//             a one-cycle yummy pulse to that channel's sender.
//  Ports    : clk_i, rstn_i (async, active-low)
//             valid_i/data_i  - per-channel inbound flits
//             yummy_o         - per-channel credit return pulses
//             out_valid_o/out_data_o/out_chan_o, out_ready_i - output slot
//             err_o           - sticky per-channel overflow flags
//  Config   : METRO_MPI_RX_OVERFLOW_CHECK_EN enables sticky err_o flags and
//             an overflow message; otherwise err_o is tied low.
//  Revision : 1.0  initial release
// ============================================================================
module mpi_rx_arbiter
    import metro_mpi_pkg::*;
#(
    parameter  int NUM_CH = 3,
    parameter  int DEPTH  = 2,
    localparam int CH_W   = $clog2(NUM_CH)
) (
    input  logic                   clk_i,
    input  logic                   rstn_i,
    input  logic [NUM_CH-1:0]      valid_i,
    input  logic [NUM_CH-1:0][63:0] data_i,
    output logic [NUM_CH-1:0]      yummy_o,
    output logic                   out_valid_o,
    output logic [63:0]            out_data_o,
    output logic [CH_W-1:0]        out_chan_o,
    input  logic                   out_ready_i,
    output logic [NUM_CH-1:0]      err_o
);

    generate
        if (NUM_CH < 2 || NUM_CH > MPI_RX_MAX_CH) begin : g_num_ch_chk
            $error("mpi_rx_arbiter: NUM_CH out of range");
        end
    endgenerate

    logic [63:0]       w_fifo_data [NUM_CH];
    logic [NUM_CH-1:0] w_empty;
    logic [NUM_CH-1:0] w_full;
    logic [NUM_CH-1:0] w_ovf;
    logic [NUM_CH-1:0] w_pop;
    logic              w_load;
    logic              w_take;
    logic              w_grant_valid;
    logic [CH_W-1:0]   w_grant_idx;

    mpi_flit_t         r_slot;
    logic              r_slot_valid;
    logic [CH_W-1:0]   r_last;
    logic [NUM_CH-1:0] r_yummy;

    generate
        for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
            mpi_credit_fifo #(
                .DEPTH (DEPTH)
            ) u_fifo (
                .clk_i      (clk_i),
                .rstn_i     (rstn_i),
                .i_push     (valid_i[g]),
                .i_data     (data_i[g]),
                .i_pop      (w_pop[g]),
                .o_data     (w_fifo_data[g]),
                .o_empty    (w_empty[g]),
                .o_full     (w_full[g]),
                .o_overflow (w_ovf[g])
            );
        end
    endgenerate

    // Slot can take a new flit when it is empty or being drained this cycle.
    assign w_load = ~r_slot_valid | out_ready_i;

    // Scan starts one past the last grant so every requester is reached
    // within NUM_CH grants.
    always_comb begin
        w_grant_valid = 1'b0;
        w_grant_idx   = '0;
        for (int i = 1; i <= NUM_CH; i++) begin
            if (!w_grant_valid && !w_empty[rr_index(int'(r_last), i, NUM_CH)]) begin
                w_grant_valid = 1'b1;
                w_grant_idx   = CH_W'(rr_index(int'(r_last), i, NUM_CH));
            end
        end
    end

    assign w_take = w_load & w_grant_valid;

    always_comb begin
        w_pop = '0;
        if (w_take) begin
            w_pop[w_grant_idx] = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_slot       <= '0;
            r_slot_valid <= 1'b0;
            r_last       <= CH_W'(NUM_CH - 1);
            r_yummy      <= '0;
        end else begin
            // Credit goes back in the cycle right after the pop.
            r_yummy <= w_pop;
            if (w_load) begin
                r_slot_valid <= w_take;
                if (w_take) begin
                    r_slot.data <= w_fifo_data[w_grant_idx];
                    r_slot.chan <= MPI_RX_CHAN_W'(w_grant_idx);
                    r_last      <= w_grant_idx;
                end
            end
        end
    end

    assign yummy_o     = r_yummy;
    assign out_valid_o = r_slot_valid;
    assign out_data_o  = r_slot.data;
    assign out_chan_o  = r_slot.chan[CH_W-1:0];

    // Full status is consumed inside each FIFO; upper chan bits exist only
    // for the widest configuration.
    logic w_unused_status;
    assign w_unused_status = ^{w_full, r_slot.chan};

`ifdef METRO_MPI_RX_OVERFLOW_CHECK_EN
    logic [NUM_CH-1:0] r_err;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_err <= '0;
        end else begin
            r_err <= r_err | w_ovf;
            for (int c = 0; c < NUM_CH; c++) begin
                if (w_ovf[c]) begin
                    $display("[RCV ARB] overflow ch %0d", c);
                end
            end
        end
    end

    assign err_o = r_err;
`else
    logic w_unused_ovf;
    assign w_unused_ovf = |w_ovf;
    assign err_o        = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mpi_rx_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mpi_rx_arbiter
//  Purpose  : Self-checking bench for mpi_rx_arbiter (NUM_CH=3, DEPTH=2).
//             Expected flits are queued as stimulus is driven; a monitor
//             records every output handshake and yummy pulse, and each test
//             task compares the two.
//  Revision : 1.0  initial release
// ============================================================================
module tb_mpi_rx_arbiter;

    localparam int NUM_CH = 3;
    localparam int DEPTH  = 2;
`ifdef METRO_MPI_RX_OVERFLOW_CHECK_EN
    localparam logic [2:0] c_OVF_ERR = 3'b001;
`else
    localparam logic [2:0] c_OVF_ERR = 3'b000;
`endif

    typedef struct { logic [1:0] chan; logic [63:0] data; } exp_t;
    typedef struct { int cyc; logic [1:0] chan; logic [63:0] data; } obs_t;

    logic             clk = 1'b0;
    logic             rstn;
    logic [2:0]       valid_i;
    logic [2:0][63:0] data_i;
    logic [2:0]       yummy_o;
    logic             out_valid_o;
    logic [63:0]      out_data_o;
    logic [1:0]       out_chan_o;
    logic             out_ready_i;
    logic [2:0]       err_o;

    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    int   ycnt  = 0;
    int   multi = 0;
    exp_t exp_q[$];
    obs_t obs_q[$];

    always #5 clk = ~clk;

    mpi_rx_arbiter #(.NUM_CH(NUM_CH), .DEPTH(DEPTH)) dut (
        .clk_i       (clk),
        .rstn_i      (rstn),
        .valid_i     (valid_i),
        .data_i      (data_i),
        .yummy_o     (yummy_o),
        .out_valid_o (out_valid_o),
        .out_data_o  (out_data_o),
        .out_chan_o  (out_chan_o),
        .out_ready_i (out_ready_i),
        .err_o       (err_o)
    );

    // Mid-cycle monitor: a handshake seen here completes on the next edge.
    always @(negedge clk) begin
        obs_t o;
        cyc++;
        if (rstn && out_valid_o && out_ready_i) begin
            o.cyc = cyc; o.chan = out_chan_o; o.data = out_data_o;
            obs_q.push_back(o);
        end
        ycnt += $countones(yummy_o);
        if ($countones(yummy_o) > 1) multi++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rstn = 1'b0; valid_i = '0; data_i = '0; out_ready_i = 1'b0;
        tick(); tick();
        rstn = 1'b1;
        obs_q.delete(); exp_q.delete();
    endtask

    task automatic push_exp(input logic [1:0] ch, input logic [63:0] d);
        exp_t e;
        e.chan = ch; e.data = d;
        exp_q.push_back(e);
    endtask

    task automatic wait_out(input int n);
        for (int k = 0; k < 40 && obs_q.size() < n; k++) tick();
        tick(); tick(); tick();
    endtask

    task automatic test_reset();
        rstn = 1'b0; valid_i = '0; data_i = '0; out_ready_i = 1'b0;
        tick();
        total++; if (out_valid_o !== 1'b0) begin bad++; $display("FAIL rst_valid got=%0b exp=0", out_valid_o); end
        total++; if (out_data_o !== 64'h0) begin bad++; $display("FAIL rst_data got=%h exp=0", out_data_o); end
        total++; if (out_chan_o !== 2'd0) begin bad++; $display("FAIL rst_chan got=%0d exp=0", out_chan_o); end
        total++; if (yummy_o !== 3'b000) begin bad++; $display("FAIL rst_yummy got=%b exp=000", yummy_o); end
        total++; if (err_o !== 3'b000) begin bad++; $display("FAIL rst_err got=%b exp=000", err_o); end
        tick();
        rstn = 1'b1;
    endtask

    task automatic test_single();
        do_reset();
        out_ready_i = 1'b1;
        valid_i = 3'b001; data_i[0] = 64'hDEAD_BEEF_0000_0001;
        push_exp(2'd0, 64'hDEAD_BEEF_0000_0001);
        tick();
        valid_i = '0;
        total++; if (out_valid_o !== 1'b0) begin bad++; $display("FAIL single_early got=%0b exp=0", out_valid_o); end
        tick();
        total++; if (out_valid_o !== 1'b1 || out_chan_o !== 2'd0 || out_data_o !== 64'hDEAD_BEEF_0000_0001) begin
            bad++; $display("FAIL single_out got=%0b/%0d/%h exp=1/0/deadbeef00000001", out_valid_o, out_chan_o, out_data_o);
        end
        total++; if (yummy_o !== 3'b001) begin bad++; $display("FAIL single_yummy got=%b exp=001", yummy_o); end
        tick();
        total++; if (out_valid_o !== 1'b0 || yummy_o !== 3'b000) begin
            bad++; $display("FAIL single_after got=%0b/%b exp=0/000", out_valid_o, yummy_o);
        end
        wait_out(1);
        total++;
        if (obs_q.size() != 1) begin bad++; $display("FAIL single_count got=%0d exp=1", obs_q.size()); end
        else begin
            obs_t g = obs_q.pop_front(); exp_t e = exp_q.pop_front();
            if (g.chan !== e.chan || g.data !== e.data) begin
                bad++; $display("FAIL single_flit got=%0d/%h exp=%0d/%h", g.chan, g.data, e.chan, e.data);
            end
        end
    endtask

    task automatic test_fairness();
        int y0, m0;
        do_reset();
        y0 = ycnt; m0 = multi;
        out_ready_i = 1'b1;
        valid_i = 3'b111;
        for (int c = 0; c < 3; c++) begin data_i[c] = 64'hA000 + 64'(c); push_exp(2'(c), 64'hA000 + 64'(c)); end
        tick();
        for (int c = 0; c < 3; c++) begin data_i[c] = 64'hB000 + 64'(c); push_exp(2'(c), 64'hB000 + 64'(c)); end
        tick();
        valid_i = '0;
        wait_out(6);
        total++;
        if (obs_q.size() != 6) begin bad++; $display("FAIL fair_count got=%0d exp=6", obs_q.size()); end
        else begin
            for (int k = 0; k < 6; k++) begin
                obs_t g = obs_q.pop_front(); exp_t e = exp_q.pop_front();
                total++;
                if (g.chan !== e.chan || g.data !== e.data) begin
                    bad++; $display("FAIL fair_order%0d got=%0d/%h exp=%0d/%h", k, g.chan, g.data, e.chan, e.data);
                end
            end
        end
        total++; if (ycnt - y0 != 6) begin bad++; $display("FAIL fair_yummies got=%0d exp=6", ycnt - y0); end
        total++; if (multi != m0) begin bad++; $display("FAIL fair_onehot got=%0d exp=0", multi - m0); end
    endtask

    task automatic test_backpressure();
        int y0, held;
        do_reset();
        y0 = ycnt;
        valid_i = 3'b010; data_i[1] = 64'h1111_0001; push_exp(2'd1, 64'h1111_0001);
        tick();
        data_i[1] = 64'h1111_0002; push_exp(2'd1, 64'h1111_0002);
        tick();
        valid_i = '0;
        // Loading the empty slot is itself a pop, so that credit returns now.
        total++; if (yummy_o !== 3'b010) begin bad++; $display("FAIL bp_load_yummy got=%b exp=010", yummy_o); end
        held = 0;
        for (int k = 0; k < 10; k++) begin
            tick();
            if (out_valid_o !== 1'b1 || out_data_o !== 64'h1111_0001 || yummy_o !== 3'b000) held++;
        end
        total++; if (held != 0) begin bad++; $display("FAIL bp_hold got=%0d bad_cycles exp=0", held); end
        total++; if (ycnt - y0 != 1) begin bad++; $display("FAIL bp_hold_yummies got=%0d exp=1", ycnt - y0); end
        out_ready_i = 1'b1;
        wait_out(2);
        total++;
        if (obs_q.size() != 2) begin bad++; $display("FAIL bp_count got=%0d exp=2", obs_q.size()); end
        else begin
            total++;
            if (obs_q[1].cyc - obs_q[0].cyc != 1) begin
                bad++; $display("FAIL bp_consecutive got=%0d exp=1", obs_q[1].cyc - obs_q[0].cyc);
            end
            for (int k = 0; k < 2; k++) begin
                obs_t g = obs_q.pop_front(); exp_t e = exp_q.pop_front();
                total++;
                if (g.chan !== e.chan || g.data !== e.data) begin
                    bad++; $display("FAIL bp_flit%0d got=%0d/%h exp=%0d/%h", k, g.chan, g.data, e.chan, e.data);
                end
            end
        end
        total++; if (ycnt - y0 != 2) begin bad++; $display("FAIL bp_yummies got=%0d exp=2", ycnt - y0); end
    endtask

    task automatic test_full_pop();
        do_reset();
        valid_i = 3'b100;
        for (int k = 0; k < 4; k++) begin
            data_i[2] = 64'hF000 + 64'(k); push_exp(2'd2, 64'hF000 + 64'(k));
            if (k == 3) out_ready_i = 1'b1;   // slot drains and FIFO 2 pops while full
            tick();
        end
        valid_i = '0;
        wait_out(4);
        total++;
        if (obs_q.size() != 4) begin bad++; $display("FAIL fullpop_count got=%0d exp=4", obs_q.size()); end
        else begin
            for (int k = 0; k < 4; k++) begin
                obs_t g = obs_q.pop_front(); exp_t e = exp_q.pop_front();
                total++;
                if (g.chan !== e.chan || g.data !== e.data) begin
                    bad++; $display("FAIL fullpop_flit%0d got=%0d/%h exp=%0d/%h", k, g.chan, g.data, e.chan, e.data);
                end
            end
        end
        total++; if (err_o !== 3'b000) begin bad++; $display("FAIL fullpop_err got=%b exp=000", err_o); end
    endtask

    task automatic test_overflow();
        int y0;
        do_reset();
        y0 = ycnt;
        // Park a channel-1 flit in the slot so channel 0 sees only its FIFO.
        valid_i = 3'b010; data_i[1] = 64'h5555; push_exp(2'd1, 64'h5555);
        tick();
        valid_i = 3'b001;
        for (int k = 0; k < 3; k++) begin
            data_i[0] = 64'h0F00 + 64'(k);
            if (k < 2) push_exp(2'd0, 64'h0F00 + 64'(k));
            tick();
        end
        valid_i = '0;
        tick(); tick();
        total++; if (err_o !== c_OVF_ERR) begin bad++; $display("FAIL ovf_err got=%b exp=%b", err_o, c_OVF_ERR); end
        out_ready_i = 1'b1;
        wait_out(3);
        total++;
        if (obs_q.size() != 3) begin bad++; $display("FAIL ovf_count got=%0d exp=3", obs_q.size()); end
        else begin
            for (int k = 0; k < 3; k++) begin
                obs_t g = obs_q.pop_front(); exp_t e = exp_q.pop_front();
                total++;
                if (g.chan !== e.chan || g.data !== e.data) begin
                    bad++; $display("FAIL ovf_flit%0d got=%0d/%h exp=%0d/%h", k, g.chan, g.data, e.chan, e.data);
                end
            end
        end
        total++; if (err_o !== c_OVF_ERR) begin bad++; $display("FAIL ovf_sticky got=%b exp=%b", err_o, c_OVF_ERR); end
        total++; if (ycnt - y0 != 3) begin bad++; $display("FAIL ovf_yummies got=%0d exp=3", ycnt - y0); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        valid_i = 3'b110; data_i[1] = 64'h7771; data_i[2] = 64'h7772;
        tick();
        valid_i = '0;
        tick();
        total++; if (out_valid_o !== 1'b1 || out_chan_o !== 2'd1) begin
            bad++; $display("FAIL mid_preload got=%0b/%0d exp=1/1", out_valid_o, out_chan_o);
        end
        #2 rstn = 1'b0;
        #1;
        total++; if (out_valid_o !== 1'b0 || out_data_o !== 64'h0 || out_chan_o !== 2'd0 || yummy_o !== 3'b000 || err_o !== 3'b000) begin
            bad++; $display("FAIL mid_async got=%0b/%h/%0d/%b/%b exp=0/0/0/000/000", out_valid_o, out_data_o, out_chan_o, yummy_o, err_o);
        end
        tick(); tick();
        rstn = 1'b1;
        obs_q.delete(); exp_q.delete();
        out_ready_i = 1'b1;
        valid_i = 3'b111;
        for (int c = 0; c < 3; c++) begin data_i[c] = 64'hC000 + 64'(c); push_exp(2'(c), 64'hC000 + 64'(c)); end
        tick();
        valid_i = '0;
        wait_out(3);
        total++;
        if (obs_q.size() != 3) begin bad++; $display("FAIL mid_count got=%0d exp=3", obs_q.size()); end
        else begin
            for (int k = 0; k < 3; k++) begin
                obs_t g = obs_q.pop_front(); exp_t e = exp_q.pop_front();
                total++;
                if (g.chan !== e.chan || g.data !== e.data) begin
                    bad++; $display("FAIL mid_flit%0d got=%0d/%h exp=%0d/%h", k, g.chan, g.data, e.chan, e.data);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_fairness();
        test_backpressure();
        test_full_pop();
        test_overflow();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
